// File: rtl/sca_window_ctrl.sv
// Single-channel-analyzer window controller: owns the comparator thresholds,
// qualifies pulses from the registered low/high flags and enforces a dead time.
module sca_window_ctrl #(
  parameter int ADC_WIDTH         = 14,
  parameter int WIDTH_BITS        = 8,
  parameter int DEAD_BITS         = 16,
  parameter int DEFAULT_LOW       = -4096,
  parameter int DEFAULT_HIGH      = 4095,
  parameter int DEFAULT_MIN_WIDTH = 4,
  parameter int DEFAULT_DEAD      = 16
) (
  input  logic                        adc_clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic signed [ADC_WIDTH-1:0] cfg_low,
  input  logic signed [ADC_WIDTH-1:0] cfg_high,
  input  logic [WIDTH_BITS-1:0]       cfg_min_width,
  input  logic [DEAD_BITS-1:0]        cfg_dead,
  output logic signed [ADC_WIDTH-1:0] thr_low,
  output logic signed [ADC_WIDTH-1:0] thr_high,
  input  logic                        vgl,
  input  logic                        vgh,
  input  logic                        cnt_clr,
  output logic                        sca_pulse,
  output logic                        reject_pulse,
  output logic                        busy,
  output logic [31:0]                 pulse_count
);

  typedef enum logic [2:0] {IDLE, ARM, READY, PULSE, DEAD} state_t;

  localparam logic [WIDTH_BITS-1:0] WIDTH_MAX = '1;

  state_t                state;
  logic [1:0]            settle;
  logic [WIDTH_BITS-1:0] width;
  logic                  over;
  logic [DEAD_BITS-1:0]  dead_cnt;
  logic [WIDTH_BITS-1:0] min_width;
  logic [DEAD_BITS-1:0]  dead_time;
  logic                  cfg_fire;

  // Config is only taken between pulses so a window never changes mid-measurement.
  assign cfg_ready = (state == IDLE) || (state == ARM) || (state == READY);
  assign cfg_fire  = cfg_valid && cfg_ready;

  always_ff @(posedge adc_clk) begin
    if (!rst) begin
      state        <= IDLE;
      settle       <= 2'd0;
      width        <= '0;
      over         <= 1'b0;
      dead_cnt     <= '0;
      thr_low      <= ADC_WIDTH'(DEFAULT_LOW);
      thr_high     <= ADC_WIDTH'(DEFAULT_HIGH);
      min_width    <= WIDTH_BITS'(DEFAULT_MIN_WIDTH);
      dead_time    <= DEAD_BITS'(DEFAULT_DEAD);
      sca_pulse    <= 1'b0;
      reject_pulse <= 1'b0;
      busy         <= 1'b0;
      pulse_count  <= '0;
    end else begin
      // NOTE: non-blocking defaults first; a later assignment in this block to
      // the same register overrides them, which is how the strobes and the
      // clear-vs-accept priority are expressed.
      sca_pulse    <= 1'b0;
      reject_pulse <= 1'b0;
      if (cnt_clr) pulse_count <= '0;

      if (cfg_fire) begin
        thr_low   <= cfg_low;
        thr_high  <= cfg_high;
        min_width <= cfg_min_width;
        dead_time <= cfg_dead;
      end

      if (!enable) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state  <= ARM;
            settle <= 2'd2;
          end
          ARM: begin
            // settle=2 hides the two cycles a threshold change needs to reach vgl
            if (cfg_fire) begin
              settle <= 2'd2;
            end else if (settle != 2'd0) begin
              settle <= settle - 2'd1;
            end else if (!vgl) begin
              state <= READY;
            end
          end
          READY: begin
            if (cfg_fire) begin
              state  <= ARM;
              settle <= 2'd2;
            end else if (vgl) begin
              state <= PULSE;
              width <= WIDTH_BITS'(1);
              over  <= vgh;
              busy  <= 1'b1;
            end
          end
          PULSE: begin
            if (vgl) begin
              if (width != WIDTH_MAX) width <= width + WIDTH_BITS'(1);
              over <= over | vgh;
            end else begin
              state    <= DEAD;
              dead_cnt <= dead_time;
              if (!over && (width >= min_width)) begin
                sca_pulse   <= 1'b1;
                pulse_count <= cnt_clr ? 32'd1 : pulse_count + 32'd1;
              end else begin
                reject_pulse <= 1'b1;
              end
            end
          end
          DEAD: begin
            if (dead_cnt == '0) begin
              state  <= ARM;
              settle <= 2'd0;
              busy   <= 1'b0;
            end else begin
              dead_cnt <= dead_cnt - DEAD_BITS'(1);
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sca_window_ctrl.sv
// Self-checking bench for sca_window_ctrl: directed scenarios plus random flag
// traces scored against a trace-scanning reference model.
module tb_sca_window_ctrl;

  localparam int MAXN = 512;
  localparam logic [13:0] DEF_LOW  = 14'h3000;  // -4096 in 14-bit two's complement
  localparam logic [13:0] DEF_HIGH = 14'h0FFF;  // 4095

  logic        adc_clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [13:0] cfg_low = '0;
  logic [13:0] cfg_high = '0;
  logic [7:0]  cfg_min_width = '0;
  logic [15:0] cfg_dead = '0;
  logic [13:0] thr_low;
  logic [13:0] thr_high;
  logic        vgl = 1'b0;
  logic        vgh = 1'b0;
  logic        cnt_clr = 1'b0;
  logic        sca_pulse;
  logic        reject_pulse;
  logic        busy;
  logic [31:0] pulse_count;

  int n_tests = 0;
  int n_fail  = 0;

  bit          tr_vgl [MAXN];
  bit          tr_vgh [MAXN];
  bit          e_sca  [MAXN];
  bit          e_rej  [MAXN];
  bit          e_busy [MAXN];
  logic [31:0] e_cnt  [MAXN];
  int          tr_n;
  int          m_min;
  int          m_dead;
  logic [31:0] exp_count;
  int          busy_seen;
  int          rej_seen;
  logic [31:0] cnt_before;

  sca_window_ctrl dut (
    .adc_clk      (adc_clk),
    .rst          (rst),
    .enable       (enable),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_low      (cfg_low),
    .cfg_high     (cfg_high),
    .cfg_min_width(cfg_min_width),
    .cfg_dead     (cfg_dead),
    .thr_low      (thr_low),
    .thr_high     (thr_high),
    .vgl          (vgl),
    .vgh          (vgh),
    .cnt_clr      (cnt_clr),
    .sca_pulse    (sca_pulse),
    .reject_pulse (reject_pulse),
    .busy         (busy),
    .pulse_count  (pulse_count)
  );

  always #5 adc_clk = ~adc_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 unit after the rising edge.
  task automatic step(input bit en, input bit vl, input bit vh, input bit clr);
    @(negedge adc_clk);
    enable  = en;
    vgl     = vl;
    vgh     = vh;
    cnt_clr = clr;
    @(posedge adc_clk);
    #1;
  endtask

  task automatic do_config(input logic [13:0] lo, input logic [13:0] hi,
                           input logic [7:0] mw, input logic [15:0] dd);
    cfg_low       = lo;
    cfg_high      = hi;
    cfg_min_width = mw;
    cfg_dead      = dd;
    cfg_valid     = 1'b1;
    step(0, 0, 0, 0);
    cfg_valid = 1'b0;
    check("cfg thr_low", 32'(thr_low), 32'(lo));
    check("cfg thr_high", 32'(thr_high), 32'(hi));
    m_min  = int'(mw);
    m_dead = int'(dd);
  endtask

  task automatic seg(input bit v, input int len);
    for (int k = 0; k < len; k++) begin
      tr_vgl[tr_n] = v;
      tr_vgh[tr_n] = 1'b0;
      tr_n++;
    end
  endtask

  task automatic gen_random(input int n, input bit tied);
    int i;
    int gap;
    int len;
    i = 0;
    while (i < n) begin
      gap = $urandom_range(1, 6);
      len = $urandom_range(1, 9);
      for (int k = 0; k < gap && i < n; k++) begin
        tr_vgl[i] = 1'b0;
        tr_vgh[i] = 1'b0;
        i++;
      end
      for (int k = 0; k < len && i < n; k++) begin
        tr_vgl[i] = 1'b1;
        tr_vgh[i] = tied ? 1'b1 : ($urandom_range(0, 11) == 0);
        i++;
      end
    end
    tr_n = n;
  endtask

  // Reference: scan the trace pulse by pulse. Sample 0 sees enable rise from
  // idle, samples 1-2 are the settle mask, and after each dead time the search
  // for a sub-threshold baseline restarts with no mask.
  task automatic build_expect(input int n);
    int t;
    int s;
    int e;
    int w;
    bit ov;
    logic [31:0] cnt;
    for (int i = 0; i < n; i++) begin
      e_sca[i]  = 1'b0;
      e_rej[i]  = 1'b0;
      e_busy[i] = 1'b0;
    end
    t = 3;
    while (t < n) begin
      while (t < n && tr_vgl[t]) t++;
      t++;
      while (t < n && !tr_vgl[t]) t++;
      if (t >= n) break;
      s  = t;
      e  = s + 1;
      ov = tr_vgh[s];
      while (e < n && tr_vgl[e]) begin
        ov = ov | tr_vgh[e];
        e++;
      end
      for (int i = s; i < n && i <= e + m_dead; i++) e_busy[i] = 1'b1;
      if (e >= n) break;
      w = (e - s > 255) ? 255 : e - s;
      if (!ov && w >= m_min) e_sca[e] = 1'b1;
      else                   e_rej[e] = 1'b1;
      t = e + m_dead + 2;
    end
    cnt = exp_count;
    for (int i = 0; i < n; i++) begin
      if (e_sca[i]) cnt = cnt + 32'd1;
      e_cnt[i] = cnt;
    end
  endtask

  task automatic run_trace(input int n, input string tag);
    build_expect(n);
    busy_seen = 0;
    rej_seen  = 0;
    for (int t = 0; t < n; t++) begin
      step(1, tr_vgl[t], tr_vgh[t], 0);
      check($sformatf("%s sca t=%0d", tag, t), 32'(sca_pulse), 32'(e_sca[t]));
      check($sformatf("%s rej t=%0d", tag, t), 32'(reject_pulse), 32'(e_rej[t]));
      check($sformatf("%s busy t=%0d", tag, t), 32'(busy), 32'(e_busy[t]));
      check($sformatf("%s ready t=%0d", tag, t), 32'(cfg_ready), 32'(!e_busy[t]));
      check($sformatf("%s count t=%0d", tag, t), pulse_count, e_cnt[t]);
      if (busy) busy_seen++;
      if (reject_pulse) rej_seen++;
    end
    exp_count = e_cnt[n-1];
    step(0, 0, 0, 0);
    check({tag, " end sca"}, 32'(sca_pulse), 32'd0);
    check({tag, " end busy"}, 32'(busy), 32'd0);
  endtask

  task automatic arm_to_ready();
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0);
    check("arm busy", 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset with random inputs.
    for (int k = 0; k < 3; k++) begin
      @(negedge adc_clk);
      enable        = 1'($urandom);
      vgl           = 1'($urandom);
      vgh           = 1'($urandom);
      cnt_clr       = 1'($urandom);
      cfg_valid     = 1'($urandom);
      cfg_low       = 14'($urandom);
      cfg_high      = 14'($urandom);
      cfg_min_width = 8'($urandom);
      cfg_dead      = 16'($urandom);
      @(posedge adc_clk);
      #1;
    end
    check("rst thr_low", 32'(thr_low), 32'(DEF_LOW));
    check("rst thr_high", 32'(thr_high), 32'(DEF_HIGH));
    check("rst sca", 32'(sca_pulse), 32'd0);
    check("rst rej", 32'(reject_pulse), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst count", pulse_count, 32'd0);
    cfg_valid = 1'b0;
    @(negedge adc_clk);
    rst = 1'b1;
    step(0, 0, 0, 0);
    check("rst ready", 32'(cfg_ready), 32'd1);
    exp_count = '0;

    // Accept: 5-cycle pulse, min width 4, dead 3.
    do_config(14'd500, 14'd3000, 8'd4, 16'd3);
    tr_n = 0; seg(0, 5); seg(1, 5); seg(0, 10);
    run_trace(tr_n, "accept");
    check("accept busy cycles", 32'(busy_seen), 32'd9);
    check("accept count", pulse_count, 32'd1);

    // Too short.
    tr_n = 0; seg(0, 5); seg(1, 3); seg(0, 10);
    run_trace(tr_n, "short");
    check("short count", pulse_count, 32'd1);

    // Over-range for one cycle mid-pulse.
    tr_n = 0; seg(0, 5); seg(1, 6); seg(0, 10);
    tr_vgh[8] = 1'b1;
    run_trace(tr_n, "overrange");
    check("overrange count", pulse_count, 32'd1);

    // Baseline arming, then a second pulse inside the dead time.
    tr_n = 0; seg(1, 8); seg(0, 3); seg(1, 5); seg(0, 1); seg(1, 2); seg(0, 12);
    run_trace(tr_n, "baseline");
    check("baseline count", pulse_count, 32'd2);

    // Inverted window: every pulse rejects.
    do_config(14'd300, 14'd200, 8'd4, 16'd3);
    cnt_before = exp_count;
    gen_random(200, 1'b1);
    run_trace(tr_n, "inverted");
    check("inverted count", pulse_count, cnt_before);
    check("inverted saw rejects", 32'(rej_seen != 0), 32'd1);

    // Config raised mid-pulse waits for the first ARM cycle.
    do_config(14'd0, 14'd3000, 8'd4, 16'd3);
    arm_to_ready();
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 0, 0);
      check("midcfg ready pulse", 32'(cfg_ready), 32'd0);
    end
    cfg_low = 14'd100; cfg_high = 14'd2000; cfg_min_width = 8'd4; cfg_dead = 16'd3;
    cfg_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step(1, 1, 0, 0);
      check("midcfg ready held", 32'(cfg_ready), 32'd0);
      check("midcfg thr held", 32'(thr_low), 32'd0);
    end
    step(1, 0, 0, 0);
    exp_count = exp_count + 32'd1;
    check("midcfg sca", 32'(sca_pulse), 32'd1);
    check("midcfg count", pulse_count, exp_count);
    check("midcfg ready dead", 32'(cfg_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0);
      check("midcfg ready dead", 32'(cfg_ready), 32'd0);
    end
    step(1, 0, 0, 0);
    check("midcfg ready arm", 32'(cfg_ready), 32'd1);
    check("midcfg thr before", 32'(thr_low), 32'd0);
    step(1, 0, 0, 0);
    cfg_valid = 1'b0;
    check("midcfg thr_low", 32'(thr_low), 32'd100);
    check("midcfg thr_high", 32'(thr_high), 32'd2000);
    step(1, 0, 0, 0);
    check("mask busy 1", 32'(busy), 32'd0);
    step(1, 1, 0, 0);
    check("mask busy 2", 32'(busy), 32'd0);
    step(1, 0, 0, 0);
    check("mask ready", 32'(busy), 32'd0);
    step(1, 1, 0, 0);
    check("mask pulse", 32'(busy), 32'd1);

    // Abort mid-pulse.
    step(0, 0, 0, 0);
    check("abort sca", 32'(sca_pulse), 32'd0);
    check("abort rej", 32'(reject_pulse), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort count", pulse_count, exp_count);
    step(0, 0, 0, 0);
    check("abort sca late", 32'(sca_pulse), 32'd0);
    check("abort rej late", 32'(reject_pulse), 32'd0);

    // Counter clear, alone and coincident with an accept.
    step(0, 0, 0, 1);
    check("clr count", pulse_count, 32'd0);
    arm_to_ready();
    for (int k = 0; k < 4; k++) step(1, 1, 0, 0);
    step(1, 0, 0, 1);
    check("clr+accept sca", 32'(sca_pulse), 32'd1);
    check("clr+accept count", pulse_count, 32'd1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    exp_count = 32'd1;

    // Counter wrap.
    force dut.pulse_count = 32'hFFFF_FFFF;
    step(0, 0, 0, 0);
    release dut.pulse_count;
    exp_count = 32'hFFFF_FFFF;
    tr_n = 0; seg(0, 5); seg(1, 5); seg(0, 10);
    run_trace(tr_n, "wrap");
    check("wrap count", pulse_count, 32'd0);

    // Reset mid-pulse.
    arm_to_ready();
    for (int k = 0; k < 5; k++) step(1, 1, 0, 0);
    @(negedge adc_clk);
    rst = 1'b0;
    step(1, 0, 0, 0);
    check("midrst sca", 32'(sca_pulse), 32'd0);
    check("midrst rej", 32'(reject_pulse), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst count", pulse_count, 32'd0);
    check("midrst thr_low", 32'(thr_low), 32'(DEF_LOW));
    step(0, 0, 0, 0);
    @(negedge adc_clk);
    rst = 1'b1;
    step(0, 0, 0, 0);
    check("midrst ready", 32'(cfg_ready), 32'd1);
    exp_count = '0;
    m_min  = 4;
    m_dead = 16;

    // Random traces, the first on reset defaults.
    for (int r = 0; r < 6; r++) begin
      if (r != 0)
        do_config(14'($urandom), 14'($urandom), 8'($urandom_range(0, 8)),
                  16'($urandom_range(0, 12)));
      gen_random(300, 1'b0);
      run_trace(tr_n, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
